// File: rtl/ps4_priority_select_pkg.sv
// Shared constants and types for the 4-way fixed-priority selector.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ps4_priority_select_pkg;

    localparam int PS_REQ_N = 4;
    localparam int PS_IDX_W = 2;

    // Request / grant vector, bit PS_REQ_N-1 is highest priority.
    typedef logic [PS_REQ_N-1:0] ps_vec_t;
    typedef logic [PS_IDX_W-1:0] ps_idx_t;

    // Reset value of the registered grant: nothing granted.
    localparam ps_vec_t PS_GNT_RST = '0;
    localparam ps_idx_t PS_IDX_RST = '0;

endpackage

// File: rtl/ps4_priority_select_ps2.sv
// 2-way fixed-priority leaf: bit 1 beats bit 0, gated by an enable.
// Latency: purely combinational, zero cycles.
// Backpressure: none; req_up reports raw request presence for the parent.
module ps2_priority_select (
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       req_up
);

    // req_up is ungated so the parent can mask lower groups even when this
    // group itself is disabled.
    always_comb begin
        req_up = req[1] | req[0];
        gnt[1] = en & req[1];
        gnt[0] = en & req[0] & ~req[1];
    end

endmodule

// File: rtl/ps4_priority_select.sv
// 4-way fixed-priority selector (bit 3 highest) with combinational and registered grants.
// Latency: gnt/gnt_idx/gnt_any zero cycles; *_q outputs one clock cycle.
// Backpressure: none; requesters are granted or not every cycle, no state held.
module ps4_priority_select
    import ps4_priority_select_pkg::*;
(
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] req,
    input  logic       en,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_any,
    output logic [3:0] gnt_q,
    output logic [1:0] gnt_idx_q,
    output logic       gnt_any_q
);

    ps_vec_t    gnt_c;
    ps_idx_t    idx_c;
    logic       any_c;
    logic       hi_req_up;
    logic       lo_req_up;
    logic       lo_en;

    // Upper pair owns the top two priorities and only sees the global enable.
    ps2_priority_select u_hi (
        .req    (req[3:2]),
        .en     (en),
        .gnt    (gnt_c[3:2]),
        .req_up (hi_req_up)
    );

    // Lower pair is starved whenever anything in the upper pair is requesting.
    assign lo_en = en & ~hi_req_up;

    ps2_priority_select u_lo (
        .req    (req[1:0]),
        .en     (lo_en),
        .gnt    (gnt_c[1:0]),
        .req_up (lo_req_up)
    );

    // Index encoder: valid because gnt_c is zero or one-hot; zero grant maps to 0.
    always_comb begin
        idx_c[1] = gnt_c[3] | gnt_c[2];
        idx_c[0] = gnt_c[3] | gnt_c[1];
        any_c    = |gnt_c;
    end

    assign gnt     = gnt_c;
    assign gnt_idx = idx_c;
    assign gnt_any = any_c;

    // Pipeline copy of the grant; async reset drops any captured grant.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            gnt_q     <= PS_GNT_RST;
            gnt_idx_q <= PS_IDX_RST;
            gnt_any_q <= 1'b0;
        end else begin
            gnt_q     <= gnt_c;
            gnt_idx_q <= idx_c;
            gnt_any_q <= any_c;
        end
    end

    // lo_req_up is not needed at this level; the leaf exposes it for deeper trees.
    logic unused_lo_req_up;
    assign unused_lo_req_up = lo_req_up;

endmodule

// File: tb/tb_ps4_priority_select.sv
// Directed bench for ps4_priority_select: combinational grant table, full sweep,
// registered path, asynchronous reset and enable-drop behaviour.
module tb_ps4_priority_select;

    logic       clock;
    logic       reset_n;
    logic [3:0] req;
    logic       en;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       gnt_any;
    logic [3:0] gnt_q;
    logic [1:0] gnt_idx_q;
    logic       gnt_any_q;

    int n_checks = 0;
    int n_fail   = 0;

    ps4_priority_select dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .en        (en),
        .gnt       (gnt),
        .gnt_idx   (gnt_idx),
        .gnt_any   (gnt_any),
        .gnt_q     (gnt_q),
        .gnt_idx_q (gnt_idx_q),
        .gnt_any_q (gnt_any_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic test_reset();
        reset_n = 1'b0;
        en      = 1'b1;
        req     = 4'b0100;
        #2;
        n_checks++;
        if (gnt_q !== 4'b0000) begin
            n_fail++; $display("FAIL reset_gnt_q: got %b expected 0000", gnt_q);
        end
        n_checks++;
        if (gnt_idx_q !== 2'b00) begin
            n_fail++; $display("FAIL reset_gnt_idx_q: got %b expected 00", gnt_idx_q);
        end
        n_checks++;
        if (gnt_any_q !== 1'b0) begin
            n_fail++; $display("FAIL reset_gnt_any_q: got %b expected 0", gnt_any_q);
        end
        // Combinational path must work with reset held.
        n_checks++;
        if (gnt !== 4'b0100) begin
            n_fail++; $display("FAIL reset_comb_gnt: got %b expected 0100", gnt);
        end
        // Hold reset across an edge, then release mid-cycle.
        @(posedge clock); #1;
        n_checks++;
        if (gnt_q !== 4'b0000) begin
            n_fail++; $display("FAIL reset_hold_gnt_q: got %b expected 0000", gnt_q);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        logic [3:0] reqs [5];
        logic [3:0] exp_g [5];
        logic [1:0] exp_i [5];
        logic       exp_a [5];
        reqs[0] = 4'b0000; exp_g[0] = 4'b0000; exp_i[0] = 2'd0; exp_a[0] = 1'b0;
        reqs[1] = 4'b1000; exp_g[1] = 4'b1000; exp_i[1] = 2'd3; exp_a[1] = 1'b1;
        reqs[2] = 4'b0100; exp_g[2] = 4'b0100; exp_i[2] = 2'd2; exp_a[2] = 1'b1;
        reqs[3] = 4'b0010; exp_g[3] = 4'b0010; exp_i[3] = 2'd1; exp_a[3] = 1'b1;
        reqs[4] = 4'b0001; exp_g[4] = 4'b0001; exp_i[4] = 2'd0; exp_a[4] = 1'b1;
        en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            req = reqs[k];
            #2;
            n_checks++;
            if (gnt !== exp_g[k]) begin
                n_fail++; $display("FAIL single_gnt req=%b: got %b expected %b", req, gnt, exp_g[k]);
            end
            n_checks++;
            if (gnt_idx !== exp_i[k]) begin
                n_fail++; $display("FAIL single_idx req=%b: got %0d expected %0d", req, gnt_idx, exp_i[k]);
            end
            n_checks++;
            if (gnt_any !== exp_a[k]) begin
                n_fail++; $display("FAIL single_any req=%b: got %b expected %b", req, gnt_any, exp_a[k]);
            end
        end
    endtask

    task automatic test_multi();
        logic [3:0] reqs [4];
        logic [3:0] exp_g [4];
        logic [1:0] exp_i [4];
        reqs[0] = 4'b0101; exp_g[0] = 4'b0100; exp_i[0] = 2'd2;
        reqs[1] = 4'b0110; exp_g[1] = 4'b0100; exp_i[1] = 2'd2;
        reqs[2] = 4'b1110; exp_g[2] = 4'b1000; exp_i[2] = 2'd3;
        reqs[3] = 4'b1111; exp_g[3] = 4'b1000; exp_i[3] = 2'd3;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req = reqs[k];
            #2;
            n_checks++;
            if (gnt !== exp_g[k]) begin
                n_fail++; $display("FAIL multi_gnt req=%b: got %b expected %b", req, gnt, exp_g[k]);
            end
            n_checks++;
            if (gnt_idx !== exp_i[k]) begin
                n_fail++; $display("FAIL multi_idx req=%b: got %0d expected %0d", req, gnt_idx, exp_i[k]);
            end
        end
    endtask

    task automatic test_disable();
        logic [3:0] reqs [2];
        reqs[0] = 4'b1111;
        reqs[1] = 4'b0110;
        en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            req = reqs[k];
            #2;
            n_checks++;
            if (gnt !== 4'b0000) begin
                n_fail++; $display("FAIL disable_gnt req=%b: got %b expected 0000", req, gnt);
            end
            n_checks++;
            if (gnt_any !== 1'b0) begin
                n_fail++; $display("FAIL disable_any req=%b: got %b expected 0", req, gnt_any);
            end
            n_checks++;
            if (gnt_idx !== 2'b00) begin
                n_fail++; $display("FAIL disable_idx req=%b: got %b expected 00", req, gnt_idx);
            end
        end
    endtask

    // Sweep every {en, req}; the reference scans from the top bit down.
    task automatic test_sweep();
        logic [3:0] exp_g;
        logic [1:0] exp_i;
        logic       exp_a;
        for (int v = 0; v < 32; v++) begin
            en  = v[4];
            req = v[3:0];
            exp_g = 4'b0000;
            exp_i = 2'd0;
            exp_a = 1'b0;
            if (en) begin
                for (int b = 3; b >= 0; b--) begin
                    if (req[b] && !exp_a) begin
                        exp_g[b] = 1'b1;
                        exp_i    = 2'(b);
                        exp_a    = 1'b1;
                    end
                end
            end
            #2;
            n_checks++;
            if (gnt !== exp_g || gnt_idx !== exp_i || gnt_any !== exp_a) begin
                n_fail++;
                $display("FAIL sweep en=%b req=%b: got gnt=%b idx=%0d any=%b expected gnt=%b idx=%0d any=%b",
                         en, req, gnt, gnt_idx, gnt_any, exp_g, exp_i, exp_a);
            end
            n_checks++;
            if (!$onehot0(gnt)) begin
                n_fail++; $display("FAIL sweep_onehot en=%b req=%b: got %b expected zero or one-hot", en, req, gnt);
            end
        end
    endtask

    task automatic test_registered();
        @(posedge clock); #1;
        en  = 1'b1;
        req = 4'b0010;
        @(posedge clock); #1;
        n_checks++;
        if (gnt_q !== 4'b0010) begin
            n_fail++; $display("FAIL reg_gnt_q: got %b expected 0010", gnt_q);
        end
        n_checks++;
        if (gnt_idx_q !== 2'd1) begin
            n_fail++; $display("FAIL reg_idx_q: got %0d expected 1", gnt_idx_q);
        end
        n_checks++;
        if (gnt_any_q !== 1'b1) begin
            n_fail++; $display("FAIL reg_any_q: got %b expected 1", gnt_any_q);
        end
        req = 4'b1000;
        #2;
        n_checks++;
        if (gnt_q !== 4'b0010) begin
            n_fail++; $display("FAIL reg_hold_before_edge: got %b expected 0010", gnt_q);
        end
        @(posedge clock); #1;
        n_checks++;
        if (gnt_q !== 4'b1000) begin
            n_fail++; $display("FAIL reg_update_gnt_q: got %b expected 1000", gnt_q);
        end
        n_checks++;
        if (gnt_idx_q !== 2'd3) begin
            n_fail++; $display("FAIL reg_update_idx_q: got %0d expected 3", gnt_idx_q);
        end
    endtask

    // Enters with gnt_q = 1000 and req = 1000, en = 1.
    task automatic test_reset_mid();
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (gnt_q !== 4'b0000 || gnt_idx_q !== 2'b00 || gnt_any_q !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: got gnt_q=%b idx_q=%b any_q=%b expected 0000/00/0",
                     gnt_q, gnt_idx_q, gnt_any_q);
        end
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++; $display("FAIL midreset_comb: got %b expected 1000", gnt);
        end
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (gnt_q !== 4'b0000) begin
            n_fail++; $display("FAIL midreset_no_replay: got %b expected 0000", gnt_q);
        end
        @(posedge clock); #1;
        n_checks++;
        if (gnt_q !== 4'b1000 || gnt_any_q !== 1'b1) begin
            n_fail++; $display("FAIL midreset_resume: got gnt_q=%b any_q=%b expected 1000/1", gnt_q, gnt_any_q);
        end
    endtask

    task automatic test_en_drop();
        req = 4'b0001;
        en  = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (gnt_q !== 4'b0000 || gnt_any_q !== 1'b0 || gnt_idx_q !== 2'b00) begin
            n_fail++;
            $display("FAIL en_drop: got gnt_q=%b idx_q=%b any_q=%b expected 0000/00/0",
                     gnt_q, gnt_idx_q, gnt_any_q);
        end
    endtask

    // One new request pattern per cycle; registered outputs trail by one edge.
    task automatic test_back_to_back();
        logic [3:0] reqs [4];
        logic [3:0] exp_q [4];
        logic [1:0] exp_i [4];
        reqs[0] = 4'b0011; exp_q[0] = 4'b0010; exp_i[0] = 2'd1;
        reqs[1] = 4'b0001; exp_q[1] = 4'b0001; exp_i[1] = 2'd0;
        reqs[2] = 4'b0111; exp_q[2] = 4'b0100; exp_i[2] = 2'd2;
        reqs[3] = 4'b0000; exp_q[3] = 4'b0000; exp_i[3] = 2'd0;
        en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req = reqs[k];
            @(posedge clock); #1;
            n_checks++;
            if (gnt_q !== exp_q[k] || gnt_idx_q !== exp_i[k]) begin
                n_fail++;
                $display("FAIL b2b step %0d: got gnt_q=%b idx_q=%0d expected %b/%0d",
                         k, gnt_q, gnt_idx_q, exp_q[k], exp_i[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_disable();
        test_sweep();
        test_registered();
        test_reset_mid();
        test_en_drop();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
